// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle between two pipeline stages.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The master may change data or drop valid at any time; only a cycle with valid & ready moves a bundle.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and NOP bubble insertion.
// Optional stall counter is enabled by defining PIPE_STAGE_PERF_EN; otherwise stall_cycles reads 0.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_reg_if.slave         in_if,
  pipe_stage_reg_if.master        out_if,
  output logic [1:0]              occupancy,
  output logic [31:0]             stall_cycles
);

  // Encoding equals the number of held entries, so occupancy doubles as the FSM debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;

  // Ready and valid come from the state register only, so no combinational path crosses the stage.
  assign in_if.ready  = (state != FULL);
  assign out_if.valid = (state != EMPTY);
  assign out_if.data  = main_q;
  assign occupancy    = state;

  assign accept  = in_if.valid & in_if.ready;
  assign consume = out_if.valid & out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_if.data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_if.data;
          end else if (accept) begin
            state  <= FULL;
            skid_q <= in_if.data;
          end else if (consume) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
          end
        end
        FULL: begin
          if (consume) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= NOP_VALUE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where a real bundle waits on downstream; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_if.valid && !out_if.ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_if.valid && !out_if.ready && !flush) |=> (out_if.valid && $stable(out_if.data)));

  a_legal_state: assert property (@(posedge clk) disable iff (rst)
    (occupancy != 2'd3));

  a_bubble_is_nop: assert property (@(posedge clk) disable iff (rst)
    (!out_if.valid) |-> (out_if.data == NOP_VALUE));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg; a negedge monitor keeps the expected-bundle queue.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef PIPE_STAGE_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;
  logic [31:0] stall_cycles;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg_if #(.WIDTH(W)) in_if ();
  pipe_stage_reg_if #(.WIDTH(W)) out_if ();

  pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_if        (in_if),
    .out_if       (out_if),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard: push on accept, pop and compare on consume, clear on flush/rst.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_if.valid && out_if.ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_spurious: out_data=%h consumed, required no bundle", out_if.data);
        end else begin
          exp = exp_q.pop_front();
          if (out_if.data !== exp) begin
            n_fail++;
            $display("FAIL sb_order: out_data=%h, required %h", out_if.data, exp);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_if.valid && in_if.ready) exp_q.push_back(in_if.data);
    end
  end

  // Driver: advance one edge, then settle away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'hDEADBEEF; out_if.ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0; in_if.valid = 1'b0;
    n_tests++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_if.ready); end
    n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_if.valid); end
    n_tests++; if (out_if.data !== NOP) begin n_fail++; $display("FAIL rst_out_data: got %h, required %h", out_if.data, NOP); end
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d, required 0", occupancy); end
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_stall: got %0d, required 0", stall_cycles); end
  endtask

  task automatic test_streaming();
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_if.data = 32'(i);
      n_tests++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: got %b, required 1", in_if.ready); end
      cycle();
      n_tests++; if (out_if.data !== 32'(i)) begin n_fail++; $display("FAIL stream_data: got %h, required %h", out_if.data, 32'(i)); end
      n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occupancy: got %0d, required 1", occupancy); end
    end
    in_if.valid = 1'b0;
    cycle();
    n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b, required 0", out_if.valid); end
    n_tests++; if (out_if.data !== NOP) begin n_fail++; $display("FAIL stream_drain_data: got %h, required %h", out_if.data, NOP); end
  endtask

  task automatic fill_a_b();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'hA;
    cycle();
    in_if.data = 32'hB;
    cycle();
    n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL fill_occupancy: got %0d, required 2", occupancy); end
    n_tests++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b, required 0", in_if.ready); end
    n_tests++; if (out_if.data !== 32'hA) begin n_fail++; $display("FAIL fill_out_data: got %h, required %h", out_if.data, 32'hA); end
  endtask

  task automatic test_skid();
    fill_a_b();
    in_if.data = 32'hC;
    cycle();
    n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_full_hold_occ: got %0d, required 2", occupancy); end
    n_tests++; if (out_if.data !== 32'hA) begin n_fail++; $display("FAIL skid_full_hold_data: got %h, required %h", out_if.data, 32'hA); end
    in_if.valid = 1'b0; out_if.ready = 1'b1;
    cycle();
    n_tests++; if (out_if.data !== 32'hB) begin n_fail++; $display("FAIL skid_drain_b: got %h, required %h", out_if.data, 32'hB); end
    n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_drain_occ1: got %0d, required 1", occupancy); end
    cycle();
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL skid_drain_occ0: got %0d, required 0", occupancy); end
    n_tests++; if (out_if.data !== NOP) begin n_fail++; $display("FAIL skid_drain_nop: got %h, required %h", out_if.data, NOP); end
  endtask

  task automatic test_flush_full();
    fill_a_b();
    flush = 1'b1; in_if.valid = 1'b1; in_if.data = 32'hC;
    cycle();
    flush = 1'b0; in_if.valid = 1'b0;
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d, required 0", occupancy); end
    n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, required 0", out_if.valid); end
    n_tests++; if (out_if.data !== NOP) begin n_fail++; $display("FAIL flush_out_data: got %h, required %h", out_if.data, NOP); end
    out_if.ready = 1'b1;
    cycle(); cycle();
    n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_c: got valid %b data %h, required valid 0", out_if.valid, out_if.data); end
  endtask

  task automatic test_reset_priority();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'hD;
    cycle();
    rst = 1'b1; flush = 1'b1; in_if.data = 32'hE;
    cycle();
    rst = 1'b0; flush = 1'b0; in_if.valid = 1'b0;
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL prio_occupancy: got %0d, required 0", occupancy); end
    n_tests++; if (out_if.data !== NOP) begin n_fail++; $display("FAIL prio_out_data: got %h, required %h", out_if.data, NOP); end
    n_tests++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL prio_in_ready: got %b, required 1", in_if.ready); end
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL prio_stall: got %0d, required 0", stall_cycles); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall;
    exp_stall = (PERF != 0) ? 32'd5 : 32'd0;
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'h55;
    cycle();
    in_if.valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    n_tests++; if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL perf_count: got %0d, required %0d", stall_cycles, exp_stall); end
    flush = 1'b1; out_if.ready = 1'b1;
    cycle();
    flush = 1'b0; out_if.ready = 1'b0;
    cycle(); cycle();
    n_tests++; if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL perf_after_flush: got %0d, required %0d", stall_cycles, exp_stall); end
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL perf_flush_occ: got %0d, required 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      n_tests++;
      if (occupancy !== 2'(exp_q.size())) begin
        n_fail++; $display("FAIL rand_occupancy: got %0d, required %0d", occupancy, exp_q.size());
      end
      n_tests++;
      if (in_if.ready !== (exp_q.size() != 2)) begin
        n_fail++; $display("FAIL rand_in_ready: got %b, required %b", in_if.ready, (exp_q.size() != 2));
      end
      in_if.valid  = ($urandom_range(0, 3) != 0);
      in_if.data   = $urandom;
      out_if.ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
    cycle(); cycle(); cycle();
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rand_drain_occ: got %0d, required 0", occupancy); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_queue: %0d bundles never emerged, required 0", exp_q.size()); end
  endtask

  initial begin
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_reset_priority();
    test_perf();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed per-stage registers that take only a global `load`.
- Carries one WIDTH-bit bundle (packed control word, ALU result, rd, store data, mask, ...) between two stages.
- Uses a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble (NOP) insertion.
- Removes global-stall wiring: each stage stalls independently without a combinational ready path back through the pipe.

Parameters:
- WIDTH, 32, bit width of the carried bundle (for example, set to $bits of the control word plus payload).
- NOP_VALUE, 32'h00000013, value driven on out_data and loaded on reset, flush and drain. Width WIDTH, zero-extended or truncated to WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous squash of all held entries (branch mispredict or trap).
- in_valid  in  1  upstream has a bundle on in_data.
- in_ready  out  1  this stage can accept a bundle this cycle.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  out_data holds a real bundle.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  WIDTH  bundle presented downstream.
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Storage: `main` register (drives out_data) and `skid` register. State is EMPTY, ONE or FULL, encoded so that occupancy = 0, 1 or 2.
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Output decode (from state registers only, no input-to-output combinational path):
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - out_data = main.
- Priority per edge: rst > flush > normal transitions.
- rst:
  - state <= EMPTY; main <= NOP_VALUE; skid <= NOP_VALUE.
  - Outputs in the cycle after reset: in_ready=1, out_valid=0, out_data=NOP_VALUE, occupancy=0, stall_cycles=0.
- flush:
  - state <= EMPTY; main and skid <= NOP_VALUE.
  - A bundle offered the same cycle is dropped, even if in_ready=1.
  - A consume in the same cycle still counts downstream; the register itself ignores it.
- EMPTY:
  - accept -> ONE, main <= in_data.
  - Otherwise stay; main holds NOP_VALUE.
- ONE:
  - accept & consume -> ONE, main <= in_data (full-throughput pass-through, 1 bundle/cycle).
  - accept & !consume -> FULL, skid <= in_data, main held.
  - !accept & consume -> EMPTY, main <= NOP_VALUE.
  - Neither -> hold.
- FULL:
  - in_ready=0, so no accept is possible; in_valid is ignored.
  - consume -> ONE, main <= skid, skid <= NOP_VALUE.
  - Otherwise hold both registers.
- Ordering and latency:
  - Strict FIFO order; no bundle is duplicated or lost except by flush or rst.
  - Latency is 1 cycle: a bundle accepted at edge N is visible on out_data after edge N.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (except on rst or flush).
- Upstream rule: upstream may change in_data or drop in_valid at any time. A bundle transfers only on a cycle where accept=1.
- Throughput: sustained 1 bundle/cycle when out_ready stays high. A single downstream stall costs no upstream bubble, because the skid absorbs one bundle.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with out_valid=1 & out_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst; flush does not clear it.
- Not defined: stall_cycles is tied to 0 and no counter logic is generated. The port remains present.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> after release in_ready=1, out_valid=0, out_data=32'h00000013, occupancy=0.
- Streaming: out_ready=1; send 32'h1, 32'h2, 32'h3 on consecutive cycles -> same values appear on out_data one cycle later, back-to-back, occupancy stays 1, in_ready never drops.
- Skid fill and drain:
  - Send 32'hA, then 32'hB with out_ready=0 -> occupancy=2, in_ready=0, out_data=32'hA held.
  - Offer 32'hC while full -> not accepted.
  - Raise out_ready -> out_data reads 32'hA, then 32'hB, then occupancy=0 and out_data=32'h00000013.
- Flush in FULL: occupancy=2 holding 32'hA/32'hB; assert flush with in_valid=1, in_data=32'hC -> next cycle occupancy=0, out_valid=0, out_data=32'h00000013; 32'hC never appears.
- Reset priority: rst and flush together with in_valid=1 -> reset state, stall_cycles=0 (PERF build).
- Perf counter (PIPE_STAGE_PERF_EN): hold a valid bundle with out_ready=0 for 5 cycles, then flush -> stall_cycles=5 and stays 5 after flush. In a non-PERF build the same stimulus -> stall_cycles=0.
